// File: rtl/debug_snapshot_tx.sv
// Single-step debug controller: steps the pipeline one enabled cycle, snapshots tap words and
// streams them as a checksummed byte frame. Optional free-run mode under `DBG_RUN_MODE_EN`.
module debug_snapshot_tx #(
    parameter int NUM_WORDS = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_step_req,
`ifdef DBG_RUN_MODE_EN
    input  logic                   i_run_req,
    input  logic                   i_halt_in,
`endif
    input  logic [32*NUM_WORDS-1:0] i_snap_data,
    output logic                   o_pipe_en,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy
);

    localparam int FRAME_LEN = 4*NUM_WORDS + 6;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int DEPTH     = 1 << IDX_W;
    localparam int SHD_W     = 32*(NUM_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADVANCE = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;
    localparam logic [2:0] S_RUN     = 3'd5;

    logic [2:0]       r_state;
    logic [31:0]      r_cnt;
    logic [SHD_W-1:0] r_shadow;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_csum;

    logic             w_xfer;
    logic             w_halt;
    logic [IDX_W-1:0] w_b;
    logic [IDX_W-1:0] w_sel;
    logic [8*DEPTH-1:0] w_pad;
    logic [7:0]       w_bytes [DEPTH];
    logic [7:0]       w_send_byte;

`ifdef DBG_RUN_MODE_EN
    assign w_halt = i_halt_in;
`else
    assign w_halt = 1'b0;
`endif

    // Shadow holds cycle_cnt in word 0 then the tap words; byte order within each word is reversed
    // so the frame goes out MSB first.
    assign w_b    = r_idx - 1'b1;
    assign w_sel  = {w_b[IDX_W-1:2], ~w_b[1:0]};
    assign w_pad  = {{(8*DEPTH-SHD_W){1'b0}}, r_shadow};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_bytes[i] = w_pad[8*i +: 8];
        end
    end

    assign w_send_byte = (r_idx == '0) ? 8'hA5 : w_bytes[w_sel];

    assign o_tx_valid = (r_state == S_SEND) || (r_state == S_CSUM);
    assign o_tx_data  = (r_state == S_SEND) ? w_send_byte :
                        (r_state == S_CSUM) ? r_csum : 8'h00;
    assign o_busy     = (r_state != S_IDLE);
    assign o_pipe_en  = (r_state == S_ADVANCE) || ((r_state == S_RUN) && !w_halt);
    assign w_xfer     = o_tx_valid && i_tx_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_idx    <= '0;
            r_csum   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_step_req) begin
                        r_state <= S_ADVANCE;
`ifdef DBG_RUN_MODE_EN
                    end else if (i_run_req) begin
                        r_state <= S_RUN;
`endif
                    end
                end
                S_ADVANCE: begin
                    r_cnt   <= r_cnt + 32'd1;
                    r_state <= S_SETTLE;
                end
                S_RUN: begin
                    if (w_halt) begin
                        r_state <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_SETTLE: begin
                    r_shadow <= {i_snap_data, r_cnt};
                    r_idx    <= '0;
                    r_csum   <= '0;
                    r_state  <= S_SEND;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_idx != '0) begin
                            r_csum <= r_csum ^ w_send_byte;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
